// File: rtl/vx_tl_mem_arbiter.sv
// Two-to-one TileLink-UL arbiter: round-robin A channel into a single registered
// output stage, per-requester outstanding throttling, D routed by source MSB.
module vx_tl_mem_arbiter #(
  parameter int SRC_W           = 7,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clock,
  input  logic                reset_n,

  input  logic                r0_a_valid,
  output logic                r0_a_ready,
  input  logic [2:0]          r0_a_bits_opcode,
  input  logic [3:0]          r0_a_bits_size,
  input  logic [SRC_W-1:0]    r0_a_bits_source,
  input  logic [ADDR_W-1:0]   r0_a_bits_address,
  input  logic [DATA_W/8-1:0] r0_a_bits_mask,
  input  logic [DATA_W-1:0]   r0_a_bits_data,
  output logic                r0_d_valid,
  input  logic                r0_d_ready,
  output logic [2:0]          r0_d_bits_opcode,
  output logic [3:0]          r0_d_bits_size,
  output logic [SRC_W-1:0]    r0_d_bits_source,
  output logic                r0_d_bits_denied,
  output logic [DATA_W-1:0]   r0_d_bits_data,

  input  logic                r1_a_valid,
  output logic                r1_a_ready,
  input  logic [2:0]          r1_a_bits_opcode,
  input  logic [3:0]          r1_a_bits_size,
  input  logic [SRC_W-1:0]    r1_a_bits_source,
  input  logic [ADDR_W-1:0]   r1_a_bits_address,
  input  logic [DATA_W/8-1:0] r1_a_bits_mask,
  input  logic [DATA_W-1:0]   r1_a_bits_data,
  output logic                r1_d_valid,
  input  logic                r1_d_ready,
  output logic [2:0]          r1_d_bits_opcode,
  output logic [3:0]          r1_d_bits_size,
  output logic [SRC_W-1:0]    r1_d_bits_source,
  output logic                r1_d_bits_denied,
  output logic [DATA_W-1:0]   r1_d_bits_data,

  output logic                mem_a_valid,
  input  logic                mem_a_ready,
  output logic [2:0]          mem_a_bits_opcode,
  output logic [3:0]          mem_a_bits_size,
  output logic [SRC_W:0]      mem_a_bits_source,
  output logic [ADDR_W-1:0]   mem_a_bits_address,
  output logic [DATA_W/8-1:0] mem_a_bits_mask,
  output logic [DATA_W-1:0]   mem_a_bits_data,

  input  logic                mem_d_valid,
  output logic                mem_d_ready,
  input  logic [2:0]          mem_d_bits_opcode,
  input  logic [3:0]          mem_d_bits_size,
  input  logic [SRC_W:0]      mem_d_bits_source,
  input  logic                mem_d_bits_denied,
  input  logic [DATA_W-1:0]   mem_d_bits_data,

  output logic                busy,
  output logic                err
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int MASK_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {PREF_R0 = 1'b0, PREF_R1 = 1'b1} rr_e;

  rr_e              rr_q, rr_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             err_q, err_d;
  logic             reg_valid_q, reg_valid_d;

  logic [2:0]        op_q, op_d;
  logic [3:0]        size_q, size_d;
  logic [SRC_W:0]    src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic elig0, elig1, gnt_any, gnt_sel, load, capture;
  logic a_fire0, a_fire1, d_sel, d_fire, d_dec0, d_dec1, uf0, uf1;

  // Grant decision uses registered counts only, so a freed slot is usable next cycle.
  always_comb begin
    elig0   = r0_a_valid && (cnt0_q < CNT_MAX);
    elig1   = r1_a_valid && (cnt1_q < CNT_MAX);
    gnt_any = elig0 || elig1;
    gnt_sel = (elig0 && elig1) ? (rr_q == PREF_R1) : elig1;
    load    = !reg_valid_q || mem_a_ready;
    capture = load && gnt_any;
  end

  assign r0_a_ready = capture && !gnt_sel;
  assign r1_a_ready = capture && gnt_sel;
  assign a_fire0    = r0_a_valid && r0_a_ready;
  assign a_fire1    = r1_a_valid && r1_a_ready;

  assign d_sel       = mem_d_bits_source[SRC_W];
  assign mem_d_ready = d_sel ? r1_d_ready : r0_d_ready;
  assign d_fire      = mem_d_valid && mem_d_ready;
  assign d_dec0      = d_fire && !d_sel;
  assign d_dec1      = d_fire && d_sel;

  always_comb begin
    cnt0_d = cnt0_q;
    uf0    = 1'b0;
    if (a_fire0 && !d_dec0) begin
      cnt0_d = cnt0_q + 1'b1;
    end else if (d_dec0 && !a_fire0) begin
      if (cnt0_q == '0) uf0 = 1'b1;
      else              cnt0_d = cnt0_q - 1'b1;
    end
  end

  always_comb begin
    cnt1_d = cnt1_q;
    uf1    = 1'b0;
    if (a_fire1 && !d_dec1) begin
      cnt1_d = cnt1_q + 1'b1;
    end else if (d_dec1 && !a_fire1) begin
      if (cnt1_q == '0) uf1 = 1'b1;
      else              cnt1_d = cnt1_q - 1'b1;
    end
  end

  always_comb begin
    err_d       = err_q || uf0 || uf1;
    rr_d        = rr_q;
    reg_valid_d = reg_valid_q;
    if (load) reg_valid_d = gnt_any;
    if (a_fire0)      rr_d = PREF_R1;
    else if (a_fire1) rr_d = PREF_R0;
  end

  always_comb begin
    op_d   = op_q;
    size_d = size_q;
    src_d  = src_q;
    addr_d = addr_q;
    mask_d = mask_q;
    data_d = data_q;
    if (capture) begin
      if (gnt_sel) begin
        op_d   = r1_a_bits_opcode;
        size_d = r1_a_bits_size;
        src_d  = {1'b1, r1_a_bits_source};
        addr_d = r1_a_bits_address;
        mask_d = r1_a_bits_mask;
        data_d = r1_a_bits_data;
      end else begin
        op_d   = r0_a_bits_opcode;
        size_d = r0_a_bits_size;
        src_d  = {1'b0, r0_a_bits_source};
        addr_d = r0_a_bits_address;
        mask_d = r0_a_bits_mask;
        data_d = r0_a_bits_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q        <= PREF_R0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      err_q       <= 1'b0;
      reg_valid_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      err_q       <= err_d;
      reg_valid_q <= reg_valid_d;
    end
  end

  // Payload is qualified by reg_valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    op_q   <= op_d;
    size_q <= size_d;
    src_q  <= src_d;
    addr_q <= addr_d;
    mask_q <= mask_d;
    data_q <= data_d;
  end

  assign mem_a_valid        = reg_valid_q;
  assign mem_a_bits_opcode  = op_q;
  assign mem_a_bits_size    = size_q;
  assign mem_a_bits_source  = src_q;
  assign mem_a_bits_address = addr_q;
  assign mem_a_bits_mask    = mask_q;
  assign mem_a_bits_data    = data_q;

  assign r0_d_valid       = mem_d_valid && !d_sel;
  assign r0_d_bits_opcode = mem_d_bits_opcode;
  assign r0_d_bits_size   = mem_d_bits_size;
  assign r0_d_bits_source = mem_d_bits_source[SRC_W-1:0];
  assign r0_d_bits_denied = mem_d_bits_denied;
  assign r0_d_bits_data   = mem_d_bits_data;

  assign r1_d_valid       = mem_d_valid && d_sel;
  assign r1_d_bits_opcode = mem_d_bits_opcode;
  assign r1_d_bits_size   = mem_d_bits_size;
  assign r1_d_bits_source = mem_d_bits_source[SRC_W-1:0];
  assign r1_d_bits_denied = mem_d_bits_denied;
  assign r1_d_bits_data   = mem_d_bits_data;

  assign busy = reg_valid_q || (cnt0_q != '0) || (cnt1_q != '0);
  assign err  = err_q;

endmodule

// File: tb/tb_vx_tl_mem_arbiter.sv
// Randomized bench for vx_tl_mem_arbiter with an in-bench transaction-level model.
module tb_vx_tl_mem_arbiter;
  localparam int MAXO = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        a_valid [2];
  logic        a_ready [2];
  logic [2:0]  a_op    [2];
  logic [3:0]  a_sz    [2];
  logic [6:0]  a_src   [2];
  logic [31:0] a_addr  [2];
  logic [3:0]  a_mask  [2];
  logic [31:0] a_data  [2];
  logic        d_valid [2];
  logic        d_ready [2];
  logic [2:0]  d_op    [2];
  logic [3:0]  d_sz    [2];
  logic [6:0]  d_src   [2];
  logic        d_den   [2];
  logic [31:0] d_dat   [2];

  logic        ma_valid, ma_ready;
  logic [2:0]  ma_op;
  logic [3:0]  ma_sz;
  logic [7:0]  ma_src;
  logic [31:0] ma_addr;
  logic [3:0]  ma_mask;
  logic [31:0] ma_data;
  logic        md_valid, md_ready;
  logic [2:0]  md_op;
  logic [3:0]  md_sz;
  logic [7:0]  md_src;
  logic        md_den;
  logic [31:0] md_data;
  logic        busy, err;

  vx_tl_mem_arbiter #(.SRC_W(7), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_a_valid(a_valid[0]), .r0_a_ready(a_ready[0]), .r0_a_bits_opcode(a_op[0]),
    .r0_a_bits_size(a_sz[0]), .r0_a_bits_source(a_src[0]), .r0_a_bits_address(a_addr[0]),
    .r0_a_bits_mask(a_mask[0]), .r0_a_bits_data(a_data[0]),
    .r0_d_valid(d_valid[0]), .r0_d_ready(d_ready[0]), .r0_d_bits_opcode(d_op[0]),
    .r0_d_bits_size(d_sz[0]), .r0_d_bits_source(d_src[0]), .r0_d_bits_denied(d_den[0]),
    .r0_d_bits_data(d_dat[0]),
    .r1_a_valid(a_valid[1]), .r1_a_ready(a_ready[1]), .r1_a_bits_opcode(a_op[1]),
    .r1_a_bits_size(a_sz[1]), .r1_a_bits_source(a_src[1]), .r1_a_bits_address(a_addr[1]),
    .r1_a_bits_mask(a_mask[1]), .r1_a_bits_data(a_data[1]),
    .r1_d_valid(d_valid[1]), .r1_d_ready(d_ready[1]), .r1_d_bits_opcode(d_op[1]),
    .r1_d_bits_size(d_sz[1]), .r1_d_bits_source(d_src[1]), .r1_d_bits_denied(d_den[1]),
    .r1_d_bits_data(d_dat[1]),
    .mem_a_valid(ma_valid), .mem_a_ready(ma_ready), .mem_a_bits_opcode(ma_op),
    .mem_a_bits_size(ma_sz), .mem_a_bits_source(ma_src), .mem_a_bits_address(ma_addr),
    .mem_a_bits_mask(ma_mask), .mem_a_bits_data(ma_data),
    .mem_d_valid(md_valid), .mem_d_ready(md_ready), .mem_d_bits_opcode(md_op),
    .mem_d_bits_size(md_sz), .mem_d_bits_source(md_src), .mem_d_bits_denied(md_den),
    .mem_d_bits_data(md_data),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding counts, preferred requester, one-entry output slot.
  int          m_cnt [2];
  int          m_rr;
  bit          m_rv;
  bit          m_err;
  logic [2:0]  m_op;
  logic [3:0]  m_sz;
  logic [7:0]  m_src;
  logic [31:0] m_addr;
  logic [3:0]  m_mask;
  logic [31:0] m_data;
  logic [7:0]  pend[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0; m_rr = 0; m_rv = 0; m_err = 0;
    pend.delete();
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      a_valid[n] = 0; a_op[n] = 0; a_sz[n] = 0; a_src[n] = 0;
      a_addr[n] = 0; a_mask[n] = 0; a_data[n] = 0; d_ready[n] = 0;
    end
    ma_ready = 0; md_valid = 0; md_op = 0; md_sz = 0; md_src = 0; md_den = 0; md_data = 0;
  endtask

  task automatic rand_payload(input int n);
    a_op[n] = 3'($urandom_range(0, 4)); a_sz[n] = 4'($urandom_range(0, 2));
    a_src[n] = 7'($urandom); a_addr[n] = $urandom; a_mask[n] = 4'($urandom);
    a_data[n] = $urandom;
  endtask

  // Called at posedge+1 with inputs set; checks outputs, advances model past the edge.
  task automatic step(input bit from_pend);
    int g;
    bit el [2];
    bit ld, dsel, dfire, inc, dec;
    bit exp_rdy [2];
    #1;
    for (int n = 0; n < 2; n++) el[n] = a_valid[n] && (m_cnt[n] < MAXO);
    g = -1;
    if (el[0] && el[1]) g = m_rr;
    else if (el[0])     g = 0;
    else if (el[1])     g = 1;
    ld = !m_rv || ma_ready;
    for (int n = 0; n < 2; n++) begin
      exp_rdy[n] = ld && (g == n);
      chk($sformatf("r%0d_a_ready", n), 64'(a_ready[n]), 64'(exp_rdy[n]));
    end
    chk("mem_a_valid", 64'(ma_valid), 64'(m_rv));
    if (m_rv) begin
      chk("mem_a_opcode", 64'(ma_op), 64'(m_op));
      chk("mem_a_size", 64'(ma_sz), 64'(m_sz));
      chk("mem_a_source", 64'(ma_src), 64'(m_src));
      chk("mem_a_address", 64'(ma_addr), 64'(m_addr));
      chk("mem_a_mask", 64'(ma_mask), 64'(m_mask));
      chk("mem_a_data", 64'(ma_data), 64'(m_data));
    end
    dsel = md_src[7];
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("r%0d_d_valid", n), 64'(d_valid[n]), 64'(md_valid && (dsel == n[0])));
      chk($sformatf("r%0d_d_opcode", n), 64'(d_op[n]), 64'(md_op));
      chk($sformatf("r%0d_d_size", n), 64'(d_sz[n]), 64'(md_sz));
      chk($sformatf("r%0d_d_source", n), 64'(d_src[n]), 64'(md_src[6:0]));
      chk($sformatf("r%0d_d_denied", n), 64'(d_den[n]), 64'(md_den));
      chk($sformatf("r%0d_d_data", n), 64'(d_dat[n]), 64'(md_data));
    end
    chk("mem_d_ready", 64'(md_ready), 64'(d_ready[dsel]));
    chk("busy", 64'(busy), 64'(m_rv || m_cnt[0] != 0 || m_cnt[1] != 0));
    chk("err", 64'(err), 64'(m_err));
    dfire = md_valid && d_ready[dsel];

    @(posedge clock);
    #1;
    if (m_rv && ma_ready) pend.push_back(m_src);
    if (dfire && from_pend) void'(pend.pop_front());
    for (int n = 0; n < 2; n++) begin
      inc = exp_rdy[n];
      dec = dfire && (dsel == n[0]);
      if (inc && !dec) m_cnt[n]++;
      else if (dec && !inc) begin
        if (m_cnt[n] == 0) m_err = 1;
        else m_cnt[n]--;
      end
    end
    if (ld) begin
      m_rv = (g >= 0);
      if (g >= 0) begin
        m_op = a_op[g]; m_sz = a_sz[g]; m_src = {g[0], a_src[g]};
        m_addr = a_addr[g]; m_mask = a_mask[g]; m_data = a_data[g];
        m_rr = 1 - g;
      end
    end
  endtask

  task automatic drain();
    bit fp;
    a_valid[0] = 0; a_valid[1] = 0;
    for (int i = 0; i < 64; i++) begin
      if (pend.size() == 0 && !m_rv && m_cnt[0] == 0 && m_cnt[1] == 0) break;
      fp = (pend.size() > 0);
      ma_ready = 1; d_ready[0] = 1; d_ready[1] = 1;
      md_valid = fp; md_src = fp ? pend[0] : 8'h00; md_data = $urandom;
      step(fp);
    end
    md_valid = 0;
    #1 chk("drain_busy", 64'(busy), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit fp;
    bit prev;
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_mem_a_valid", 64'(ma_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    reset_n = 1;

    // Single imem Get
    a_valid[0] = 1; a_op[0] = 3'd4; a_sz[0] = 4'd2; a_src[0] = 7'h05;
    a_addr[0] = 32'h8000_0000; a_mask[0] = 4'hF; ma_ready = 1;
    step(0);
    a_valid[0] = 0;
    #1;
    chk("get_mem_a_valid", 64'(ma_valid), 64'h1);
    chk("get_mem_a_source", 64'(ma_src), 64'h05);
    chk("get_mem_a_address", 64'(ma_addr), 64'h8000_0000);
    chk("get_busy", 64'(busy), 64'h1);
    step(0);
    md_valid = 1; md_src = 8'h05; md_op = 3'd1; md_sz = 4'd2; md_data = 32'hDEAD_BEEF;
    d_ready[0] = 1;
    #1;
    chk("get_r0_d_valid", 64'(d_valid[0]), 64'h1);
    chk("get_r1_d_valid", 64'(d_valid[1]), 64'h0);
    chk("get_r0_d_data", 64'(d_dat[0]), 64'hDEAD_BEEF);
    chk("get_r0_d_source", 64'(d_src[0]), 64'h05);
    step(1);
    md_valid = 0;
    #1 chk("get_busy_after", 64'(busy), 64'h0);

    // Throttle: dmem hits the in-flight limit
    a_valid[1] = 1; a_op[1] = 3'd0; a_src[1] = 7'h11; ma_ready = 1; md_valid = 0;
    repeat (4) step(0);
    a_valid[0] = 1;
    #1;
    chk("thr_r1_a_ready_limit", 64'(a_ready[1]), 64'h0);
    chk("thr_r0_a_ready", 64'(a_ready[0]), 64'h1);
    step(0);
    a_valid[0] = 0;
    md_valid = 1; md_src = pend[0]; d_ready[1] = 1;
    #1 chk("thr_r1_a_ready_dret", 64'(a_ready[1]), 64'h0);
    step(1);
    md_valid = 0;
    #1 chk("thr_r1_a_ready_after", 64'(a_ready[1]), 64'h1);
    step(0);
    drain();

    // Backpressure: held request stays put and issues once
    a_valid[0] = 1; a_addr[0] = 32'h1234_5670; a_src[0] = 7'h22; ma_ready = 0;
    step(0);
    a_valid[1] = 1; a_addr[0] = 32'hAAAA_0000;
    repeat (3) begin
      #1;
      chk("bp_r0_a_ready", 64'(a_ready[0]), 64'h0);
      chk("bp_r1_a_ready", 64'(a_ready[1]), 64'h0);
      chk("bp_mem_a_address", 64'(ma_addr), 64'h1234_5670);
      step(0);
    end
    a_valid[0] = 0; a_valid[1] = 0; ma_ready = 1;
    step(0);
    #1 chk("bp_issued_once", 64'(ma_valid), 64'h0);
    drain();

    // Underflow on dmem with nothing outstanding
    md_valid = 1; md_src = 8'h80; d_ready[1] = 1;
    #1;
    chk("uf_r1_d_valid", 64'(d_valid[1]), 64'h1);
    chk("uf_r0_d_valid", 64'(d_valid[0]), 64'h0);
    step(0);
    md_valid = 0;
    #1;
    chk("uf_err", 64'(err), 64'h1);
    chk("uf_busy", 64'(busy), 64'h0);
    repeat (3) step(0);
    #1 chk("uf_err_sticky", 64'(err), 64'h1);

    // Contention: one grant per cycle, alternating
    a_valid[0] = 1; a_valid[1] = 1; ma_ready = 1; d_ready[0] = 1; d_ready[1] = 1;
    prev = 0;
    for (int c = 0; c < 40; c++) begin
      rand_payload(0); rand_payload(1);
      fp = (pend.size() > 0);
      md_valid = fp; md_src = fp ? pend[0] : 8'h00;
      #1;
      chk("cont_one_grant", 64'(a_ready[0] ^ a_ready[1]), 64'h1);
      if (c > 0) chk("cont_alternate", 64'(a_ready[0]), 64'(!prev));
      prev = a_ready[0];
      step(fp);
    end
    drain();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        a_valid[n] = ($urandom_range(0, 99) < 70);
        rand_payload(n);
        d_ready[n] = ($urandom_range(0, 99) < 80);
      end
      ma_ready = ($urandom_range(0, 99) < 75);
      fp = (pend.size() > 0) && ($urandom_range(0, 99) < 60);
      md_valid = fp; md_src = fp ? pend[0] : 8'($urandom);
      md_op = 3'($urandom); md_sz = 4'($urandom); md_den = 1'($urandom); md_data = $urandom;
      step(fp);
    end

    // Asynchronous reset between edges with a request held
    a_valid[0] = 1; a_valid[1] = 1; ma_ready = 0; md_valid = 0;
    step(0);
    step(0);
    #2;
    reset_n = 0;
    #1;
    chk("areset_mem_a_valid", 64'(ma_valid), 64'h0);
    chk("areset_busy", 64'(busy), 64'h0);
    chk("areset_err", 64'(err), 64'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1; ma_ready = 1;
    #1;
    chk("areset_r0_pref", 64'(a_ready[0]), 64'h1);
    chk("areset_r1_wait", 64'(a_ready[1]), 64'h0);
    step(0);
    #1 chk("areset_r1_next", 64'(a_ready[1]), 64'h1);
    step(0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
